// File: rtl/mul16_seq.sv
// Sequential shift-and-add multiplier: one shared adder, WIDTH accumulate steps per operation.
// Returns the low WIDTH product bits plus an unsigned overflow flag.
module mul16_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int unsigned ACC_W = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state, state_d;
    logic [ACC_W-1:0] mcand, mcand_d;
    logic [WIDTH-1:0] mplier, mplier_d;
    logic [ACC_W-1:0] acc, acc_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [WIDTH-1:0] out_d;
    logic             ovf_d;
    logic             busy_d;
    logic             done_d;
    logic [ACC_W-1:0] acc_sum;

    // Shared adder: full-width partial-product accumulate
    assign acc_sum = acc + (mplier[0] ? mcand : '0);

    // State and datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            out    <= '0;
            ovf    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_d;
            mcand  <= mcand_d;
            mplier <= mplier_d;
            acc    <= acc_d;
            cnt    <= cnt_d;
            out    <= out_d;
            ovf    <= ovf_d;
            busy   <= busy_d;
            done   <= done_d;
        end
    end

    // Next-state and next-output logic; busy/done are registered so they track state
    always_comb begin
        state_d  = state;
        mcand_d  = mcand;
        mplier_d = mplier;
        acc_d    = acc;
        cnt_d    = cnt;
        out_d    = out;
        ovf_d    = ovf;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    mcand_d  = ACC_W'(a);
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand << 1;
                mplier_d = mplier >> 1;
                cnt_d    = cnt + CNT_W'(1);
                busy_d   = 1'b1;
                // Fixed latency: finish on the WIDTH-th step regardless of operands
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    out_d   = acc_sum[WIDTH-1:0];
                    ovf_d   = |acc_sum[ACC_W-1:WIDTH];
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mul16_seq.sv
// Scoreboard bench for mul16_seq: stimulus queues expected results, a monitor checks each done.
module tb_mul16_seq;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] out;
    logic        ovf;
    logic        busy;
    logic        done;

    typedef struct {
        logic [15:0] out;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t expq[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    mul16_seq #(.WIDTH(16)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .out    (out),
        .ovf    (ovf),
        .busy   (busy),
        .done   (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done must match the oldest queued expectation
    always @(negedge clock) begin
        if (reset_n && done) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("result_out", int'(out), int'(e.out));
                chk("result_ovf", int'(ovf), int'(e.ovf));
                chk("done_cycle", cyc, e.cyc);
                chk("busy_with_done", int'(busy), 0);
            end
        end
    end

    // Called at a negedge: present operands, let the next edge accept, queue the expectation
    task automatic issue(input logic [15:0] ia, input logic [15:0] ib,
                         input logic [15:0] eo, input logic ev);
        exp_t e;
        a     = ia;
        b     = ib;
        start = 1'b1;
        @(negedge clock);
        start  = 1'b0;
        e.out  = eo;
        e.ovf  = ev;
        e.cyc  = cyc + 16;
        expq.push_back(e);
        a = 16'hDEAD;
        b = 16'hBEEF;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((expq.size() != 0 || busy || done) && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (n >= 60) begin
            checks++;
            failures++;
            $display("FAIL wait_idle_timeout: got %0d pending expected 0", expq.size());
        end
        @(negedge clock);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        repeat (3) @(negedge clock);
        chk("reset_out", int'(out), 0);
        chk("reset_ovf", int'(ovf), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        reset_n = 1'b1;
        @(negedge clock);

        // 1: basic op with busy/done timing
        issue(16'd3, 16'd5, 16'h000F, 1'b0);
        for (int i = 0; i < 16; i++) begin
            chk("run_busy", int'(busy), 1);
            chk("run_done", int'(done), 0);
            @(negedge clock);
        end
        chk("done_busy_low", int'(busy), 0);
        chk("done_pulse", int'(done), 1);
        @(negedge clock);
        chk("post_done", int'(done), 0);
        chk("post_busy", int'(busy), 0);
        wait_idle();

        // 2: overflow and boundary products
        issue(16'hFFFF, 16'hFFFF, 16'h0001, 1'b1); wait_idle();
        issue(16'h0100, 16'h0100, 16'h0000, 1'b1); wait_idle();
        issue(16'h00FF, 16'h0101, 16'hFFFF, 1'b0); wait_idle();
        issue(16'hFFFF, 16'h0002, 16'hFFFE, 1'b1); wait_idle();
        issue(16'hFFFF, 16'h0001, 16'hFFFF, 1'b0); wait_idle();

        // 3: zero operands keep full latency
        issue(16'h0000, 16'h1234, 16'h0000, 1'b0); wait_idle();
        issue(16'h1234, 16'h0000, 16'h0000, 1'b0); wait_idle();

        // 4: start during RUN is ignored
        issue(16'd7, 16'd9, 16'h003F, 1'b0);
        repeat (4) @(negedge clock);
        a = 16'd2; b = 16'd2; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_idle();
        repeat (20) @(negedge clock);
        chk("idle_after_ignore", int'(busy), 0);
        chk("ovf_held", int'(ovf), 0);
        chk("out_held", int'(out), 16'h003F);

        // 5: back-to-back accept in the done cycle
        issue(16'd4, 16'd4, 16'h0010, 1'b0);
        repeat (16) @(negedge clock);
        chk("b2b_done", int'(done), 1);
        issue(16'd10, 16'd10, 16'h0064, 1'b0);
        chk("b2b_no_gap", int'(busy), 1);
        chk("b2b_out_held", int'(out), 16'h0010);
        wait_idle();

        // 6: asynchronous reset mid-operation
        issue(16'h1111, 16'd3, 16'h3333, 1'b0);
        repeat (7) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("arst_out", int'(out), 0);
        chk("arst_ovf", int'(ovf), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        expq.delete();
        @(negedge clock);
        reset_n = 1'b1;
        repeat (24) @(negedge clock);
        chk("arst_still_idle", int'(busy), 0);
        issue(16'd6, 16'd7, 16'h002A, 1'b0);
        wait_idle();

        chk("queue_drained", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
